// File: rtl/nrisc_pkg.sv
// Shared NRISC constants and types for the register file and its read ports.
package nrisc_pkg;

  localparam int unsigned TAM_DEFAULT = 16;
  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned REG_ADDR_W  = 4;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 4'd0;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/nrisc_regs_rdport.sv
// One asynchronous read port: 16:1 mux with R0 forced to zero.
// NRISC_REGS_BYPASS_EN adds write-to-read forwarding ahead of the mux.
module nrisc_regs_rdport
  import nrisc_pkg::*;
#(
  parameter int unsigned TAM = TAM_DEFAULT
) (
  input  logic [TAM-1:0] regs_i [NUM_REGS],
  input  reg_idx_t       idx_i,
`ifdef NRISC_REGS_BYPASS_EN
  input  logic           wr_en_i,
  input  reg_idx_t       wr_idx_i,
  input  logic [TAM-1:0] wr_data_i,
`endif
  output logic [TAM-1:0] rd_o
);

  always_comb begin
    rd_o = regs_i[idx_i];
    if (is_zero_reg(idx_i)) begin
      rd_o = '0;
    end
`ifdef NRISC_REGS_BYPASS_EN
    else if (wr_en_i && !is_zero_reg(wr_idx_i) && (wr_idx_i == idx_i)) begin
      rd_o = wr_data_i;
    end
`endif
  end

endmodule

// File: rtl/nrisc_regs.sv
// NRISC general-purpose register file: R1..R15 storage, one write port, two read ports.
// Optional write-to-read forwarding via NRISC_REGS_BYPASS_EN.
module nrisc_regs
  import nrisc_pkg::*;
#(
  parameter int unsigned TAM = TAM_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           write,
  input  reg_idx_t       CORE_REG_RD,
  input  logic [TAM-1:0] RD,
  input  reg_idx_t       CORE_REG_RF1,
  input  reg_idx_t       CORE_REG_RF2,
  output logic [TAM-1:0] RF1,
  output logic [TAM-1:0] RF2
);

  logic [TAM-1:0] regs_q [1:NUM_REGS-1];
  logic [TAM-1:0] regs_d [1:NUM_REGS-1];
  logic [TAM-1:0] regs_view [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (write && !is_zero_reg(CORE_REG_RD)) begin
      regs_d[CORE_REG_RD] = RD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Slot 0 has no storage; present a constant so both ports share one 16-entry view.
  always_comb begin
    regs_view[0] = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  nrisc_regs_rdport #(.TAM(TAM)) u_rdport_rf1 (
    .regs_i    (regs_view),
    .idx_i     (CORE_REG_RF1),
`ifdef NRISC_REGS_BYPASS_EN
    .wr_en_i   (write),
    .wr_idx_i  (CORE_REG_RD),
    .wr_data_i (RD),
`endif
    .rd_o      (RF1)
  );

  nrisc_regs_rdport #(.TAM(TAM)) u_rdport_rf2 (
    .regs_i    (regs_view),
    .idx_i     (CORE_REG_RF2),
`ifdef NRISC_REGS_BYPASS_EN
    .wr_en_i   (write),
    .wr_idx_i  (CORE_REG_RD),
    .wr_data_i (RD),
`endif
    .rd_o      (RF2)
  );

endmodule

// File: tb/tb_nrisc_regs.sv
// Directed and randomized checks of nrisc_regs against hand-computed values and a small model.
module tb_nrisc_regs;

  logic        clk;
  logic        rst;
  logic        write;
  logic [3:0]  CORE_REG_RD;
  logic [15:0] RD;
  logic [3:0]  CORE_REG_RF1;
  logic [3:0]  CORE_REG_RF2;
  logic [15:0] RF1;
  logic [15:0] RF2;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [15:0] model [16];

  nrisc_regs #(.TAM(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .write        (write),
    .CORE_REG_RD  (CORE_REG_RD),
    .RD           (RD),
    .CORE_REG_RF1 (CORE_REG_RF1),
    .CORE_REG_RF2 (CORE_REG_RF2),
    .RF1          (RF1),
    .RF2          (RF2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  rd_idx;
    logic [15:0] data;
    logic [3:0]  rf1_idx;
    logic [3:0]  rf2_idx;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read expectation for the pre-edge window, including optional forwarding.
  function automatic logic [15:0] expect_rd(input logic [3:0] idx);
    logic [15:0] v;
    v = (idx == 4'd0) ? 16'h0000 : model[idx];
`ifdef NRISC_REGS_BYPASS_EN
    if (write && CORE_REG_RD != 4'd0 && CORE_REG_RD == idx) v = RD;
`endif
    return v;
  endfunction

  task automatic model_commit();
    if (write && CORE_REG_RD != 4'd0) model[CORE_REG_RD] = RD;
  endtask

  vec_t vecs [8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    vecs[0] = '{1'b1, 4'd0,  16'hBEEF, 4'd0,  4'd5,  16'h0000, 16'h5555};
    vecs[1] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd0,  16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 4'd3,  16'h1234, 4'd3,  4'd3,  16'h3333, 16'h3333};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd15, 16'h3333, 16'hFFFF};
    vecs[4] = '{1'b1, 4'd4,  16'hCAFE, 4'd4,  4'd4,  16'h4444, 16'h4444};
    vecs[5] = '{1'b1, 4'd4,  16'h0001, 4'd4,  4'd1,  16'hCAFE, 16'h1111};
    vecs[6] = '{1'b1, 4'd15, 16'h8000, 4'd4,  4'd15, 16'h0001, 16'hFFFF};
    vecs[7] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd2,  16'h8000, 16'h2222};

    rst = 1'b0;
    write = 1'b1;
    CORE_REG_RD = 4'd6;
    RD = 16'hDEAD;
    CORE_REG_RF1 = 4'd6;
    CORE_REG_RF2 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("write_during_reset", RF1, 16'h0000);

    @(negedge clk);
    write = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      CORE_REG_RF1 = 4'(i);
      CORE_REG_RF2 = 4'(15 - i);
      #1;
      check("reset_rf1", RF1, 16'h0000);
      check("reset_rf2", RF2, 16'h0000);
    end

    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      write = 1'b1;
      CORE_REG_RD = 4'(k);
      RD = 16'(k) * 16'h1111;
      @(posedge clk);
      #1;
      model_commit();
    end
    @(negedge clk);
    write = 1'b0;
    for (int k = 0; k < 16; k++) begin
      CORE_REG_RF1 = 4'(k);
      CORE_REG_RF2 = 4'(k);
      #1;
      check("fill_rf1", RF1, (k == 0) ? 16'h0000 : 16'(k) * 16'h1111);
      check("fill_rf2", RF2, (k == 0) ? 16'h0000 : 16'(k) * 16'h1111);
    end
    CORE_REG_RF1 = 4'd5;
    #1;
    check("fill_r5", RF1, 16'h5555);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      write = vecs[i].wr;
      CORE_REG_RD = vecs[i].rd_idx;
      RD = vecs[i].data;
      CORE_REG_RF1 = vecs[i].rf1_idx;
      CORE_REG_RF2 = vecs[i].rf2_idx;
      #1;
`ifdef NRISC_REGS_BYPASS_EN
      check("vec_rf1", RF1, expect_rd(vecs[i].rf1_idx));
      check("vec_rf2", RF2, expect_rd(vecs[i].rf2_idx));
`else
      check("vec_rf1", RF1, vecs[i].exp1);
      check("vec_rf2", RF2, vecs[i].exp2);
`endif
      @(posedge clk);
      #1;
      model_commit();
    end

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      write = 1'($urandom_range(0, 1));
      CORE_REG_RD = 4'($urandom_range(0, 15));
      RD = 16'($urandom);
      CORE_REG_RF1 = 4'($urandom_range(0, 15));
      CORE_REG_RF2 = (i % 8 == 0) ? CORE_REG_RF1 : 4'($urandom_range(0, 15));
      #1;
      check("rand_rf1", RF1, expect_rd(CORE_REG_RF1));
      check("rand_rf2", RF2, expect_rd(CORE_REG_RF2));
      @(posedge clk);
      #1;
      model_commit();
    end

    @(negedge clk);
    write = 1'b1;
    CORE_REG_RD = 4'd7;
    RD = 16'hA5A5;
    @(posedge clk);
    #1;
    model_commit();
    @(negedge clk);
    write = 1'b0;
    CORE_REG_RF1 = 4'd7;
    CORE_REG_RF2 = 4'd7;
    #1;
    check("r7_before_reset", RF1, 16'hA5A5);
    rst = 1'b0;
    #1;
    check("async_reset_rf1", RF1, 16'h0000);
    check("async_reset_rf2", RF2, 16'h0000);
    write = 1'b1;
    RD = 16'h1111;
    @(posedge clk);
    #1;
    check("write_lost_in_reset", RF1, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    write = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    #1;
    check("after_reset_r7", RF1, 16'h0000);

    @(negedge clk);
    write = 1'b1;
    CORE_REG_RD = 4'd9;
    RD = 16'h0F0F;
    @(posedge clk);
    #1;
    model_commit();
    @(negedge clk);
    CORE_REG_RD = 4'd9;
    RD = 16'h00FF;
    CORE_REG_RF2 = 4'd9;
    CORE_REG_RF1 = 4'd0;
    #1;
`ifdef NRISC_REGS_BYPASS_EN
    check("bypass_pre_edge", RF2, 16'h00FF);
`else
    check("no_bypass_pre_edge", RF2, 16'h0F0F);
`endif
    check("bypass_r0", RF1, 16'h0000);
    @(posedge clk);
    #1;
    model_commit();
    check("r9_post_edge", RF2, 16'h00FF);
    @(negedge clk);
    write = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nrisc_regs.md
# nrisc_regs

General-purpose register file of the NRISC core: sixteen TAM-bit registers, one synchronous write port and two asynchronous read ports. It sits between decode and the ALU. The write port is driven by writeback (destination index, data, enable). The two read ports supply source operands RF1 and RF2. Register 0 is hardwired to zero.

## Interface
Parameters:
- TAM, default 16: data width of every register and data port.

Ports (clock and reset first):
- clk  input  1  single clock for the block.
- rst  input  1  reset; asynchronous, active-low.
- write  input  1  write enable, sampled on the rising edge of clk.
- CORE_REG_RD  input  4  destination register index for the write.
- RD  input  TAM  write data.
- CORE_REG_RF1  input  4  index for read port 1.
- CORE_REG_RF2  input  4  index for read port 2.
- RF1  output  TAM  contents of register CORE_REG_RF1.
- RF2  output  TAM  contents of register CORE_REG_RF2.

## Operation
- Storage: registers R1..R15, each TAM bits. R0 has no storage.
- Write: on the rising edge of clk, if write=1 and CORE_REG_RD≠0, then R[CORE_REG_RD] <= RD.
  - Writes to index 0 are silently discarded.
  - If write=0, no register changes.
- Read: RF1 = R[CORE_REG_RF1] and RF2 = R[CORE_REG_RF2], purely combinational.
  - Index 0 always reads all-zeros.
  - Both ports may address the same register at once; each returns the same value independently.
- Reset: while rst=0, all R1..R15 are forced to 0 immediately, without waiting for clk.
  - RF1 and RF2 therefore read 0 for every index during and after reset, until a write occurs.
  - A write coincident with active reset is lost.
- No arithmetic; data passes through unmodified at full TAM width.

## Timing
- Write latency: data presented at rising edge N becomes visible on the read ports after edge N, in the same cycle the register updates.
- Read latency: combinational. RF1/RF2 settle within the same cycle after any change of CORE_REG_RF1/RF2 or of register contents.
- Same-cycle write and read of the same index (default build): the read port returns the old value until the clock edge, then the new value.
- Reset assertion is asynchronous. Reset deassertion is treated as synchronous to clk by the surrounding design. The first write is accepted on the first rising edge after rst goes high.
- Back-to-back writes on consecutive edges to the same or different indices are fully supported; the last write wins.

## Configuration
- Macro NRISC_REGS_BYPASS_EN selects write-to-read forwarding.
- Defined:
  - If write=1, CORE_REG_RD≠0 and CORE_REG_RD equals a read index, that read port outputs RD combinationally in the same cycle, before the edge.
  - R0 still reads 0.
- Undefined:
  - No forwarding.
  - Read ports always show stored contents, as described in Timing.

## Structure
- Shared package nrisc_pkg holds:
  - TAM default (16);
  - NUM_REGS = 16;
  - REG_ADDR_W = 4;
  - ZERO_REG = 4'd0.
- One natural sub-module, nrisc_regs_rdport: 16:1 TAM-bit read mux with zero-index override and optional bypass compare. It is instantiated twice, for RF1 and RF2.
- The top holds the storage array, write decode and asynchronous reset.

## Test plan
- Reset: hold rst=0, then release; sweep CORE_REG_RF1/RF2 over 0..15 -> RF1=RF2=16'h0000 for every index.
- Sequential fill: write=1, CORE_REG_RD = 1..15 on consecutive edges with RD=index*16'h1111 -> reading index k returns k*16'h1111 (e.g. R5=16'h5555).
- Zero register: write=1, CORE_REG_RD=0, RD=16'hBEEF -> RF1 with CORE_REG_RF1=0 reads 16'h0000.
- Write disabled: write=0, CORE_REG_RD=3, RD=16'h1234 -> R3 keeps its prior value.
- Dual read plus random: 1000 random cycles (random RD, CORE_REG_RD, CORE_REG_RF1/RF2, write) checked against a scoreboard -> both ports always match the model, including RF1 index = RF2 index.
- Mid-run reset and bypass:
  - rst=0 after R7=16'hA5A5 -> R7 reads 0 immediately, without a clock edge.
  - With NRISC_REGS_BYPASS_EN, write R9=16'h00FF with CORE_REG_RF2=9 -> RF2=16'h00FF before the edge; without it, RF2 keeps the old value until the edge.
